ahb_sram_ws: RTL and testbench
==============================

// Module: ahb_sram_ws
// PURPOSE
// AHB-Lite slave SRAM, parametrised successor of the single-port AHB memory: configurable width/depth,
// programmable wait states, hsize/haddr byte-lane masking ANDed with hwstrb, and read-after-write forwarding.
// Two-cycle ERROR response for out-of-range, oversize or unaligned transfers. Sits behind the AHB interconnect decoder.
// PARAMETERS
// HADDR_WIDTH   32   address width (10..64)
// DATA_WIDTH    64   data width, power of two, 8..1024
// MEM_DEPTH     256  words, power of two; IDX_W=$clog2(MEM_DEPTH), BOFF=$clog2(DATA_WIDTH/8)
// WAIT_STATES   0    data-phase wait cycles per transfer (0..7), applied to reads and writes alike
// HBURST_WIDTH  3    hburst width; HPROT_WIDTH 4; HMASTER_WIDTH 4 (sideband, ignored)
// PORTS
// hclk         in   1             clock
// hresetn      in   1             synchronous reset, active low
// hsel         in   1             slave select from decoder
// haddr        in   HADDR_WIDTH   byte address
// htrans       in   2             IDLE/BUSY/NONSEQ/SEQ
// hwrite       in   1             1=write
// hsize        in   3             transfer size, bytes=1<<hsize
// hburst/hprot/hmaster/hmasterlock/hnonsec  in  params/1  accepted, no effect
// hwdata       in   DATA_WIDTH    write data (data phase)
// hwstrb       in   DATA_WIDTH/8  write strobes (data phase)
// hready       in   1             bus ready
// hrdata       out  DATA_WIDTH    read data
// hreadyout    out  1             slave ready
// hresp        out  1             0=OKAY 1=ERROR
// hexokay      out  1             tied 0 (no exclusive support)
// BEHAVIOUR
// - Reset (hresetn=0 at edge): hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, pending write dropped.
//   Memory array not reset. Reset mid-transfer aborts it; an uncommitted write is lost.
// - Accept = hsel & hready & htrans[1]; IDLE/BUSY or hsel=0 -> OKAY, zero wait, no access.
// - Error at accept if: haddr[HADDR_WIDTH-1:BOFF+IDX_W]!=0, or hsize>BOFF, or haddr & ((1<<hsize)-1) != 0.
// - FSM states: IDLE, DATA, ERR1, ERR2.
//   IDLE/DATA --accept&ok--> DATA; --accept&err--> ERR1; else -> IDLE.
//   ERR1: hreadyout=0,hresp=1 -> ERR2. ERR2: hreadyout=1,hresp=1; accept evaluated as in IDLE.
//   DATA: counter loaded with WAIT_STATES at accept; hreadyout=0 while counter!=0, decrements each cycle.
// - Lane mask: size_mask = ((1<<(1<<hsize))-1) << haddr[BOFF-1:0], captured at accept; byte enable = size_mask & hwstrb.
// - Write: idx/mask captured at accept; array written on the DATA cycle with hreadyout=1, using hwdata/hwstrb then.
//   Zero enabled lanes -> OKAY, no array change.
// - Read: array read synchronously, registered into hrdata at the accept edge, held through wait states;
//   valid when hreadyout=1. Disabled lanes return stored data (full word always returned).
// - Forwarding: if the accepted read idx equals a write committing at the same edge, enabled lanes of hrdata
//   take that hwdata; other lanes from array. Result identical to read-after-write.
// - Errored transfers never touch the array; hrdata holds previous value.
// - Pipelined back-to-back transfers sustain one per cycle when WAIT_STATES=0.
// STRUCTURE
// - ahb_pkg: htrans_t enum (IDLE,BUSY,NONSEQ,SEQ), HRESP_OKAY/HRESP_ERROR, hsize_t, function lane_mask(hsize,addr_lo).
// - Sub-module sram_sp_bw: single-port array, byte write enables, synchronous read, params DATA_WIDTH/MEM_DEPTH.
// - Top holds FSM, wait counter, address-phase regs, error check, forwarding mux.
// TESTING (DATA_WIDTH=64, MEM_DEPTH=256 unless noted)
// 1 hresetn=0 for 2 cycles mid read -> hreadyout=1, hresp=0, hrdata=0 next cycle; next transfer OKAY.
// 2 write 0x10 hsize=3 data 0x1122334455667788 strb 0xFF, read 0x10 -> 0x1122334455667788, hreadyout never low.
// 3 write 0x13 hsize=0 hwdata byte3=0xAA strb 0xFF, read 0x10 -> 0x11223344AA667788 (only lane 3 changed).
// 4 pipelined write 0x20 data 0xDEADBEEFCAFEF00D then read 0x20 next cycle -> read returns 0xDEADBEEFCAFEF00D.
// 5 read 0x800 (out of range) and write 0x02 hsize=2 (unaligned) -> each: hreadyout 0/hresp 1, then 1/1; array unchanged.
// 6 WAIT_STATES=2: read 0x10 -> hreadyout low exactly 2 cycles, hrdata valid on 3rd data cycle; write likewise.

Source files
------------

// File: rtl/ahb_sram_ws_pkg.sv
// Shared AHB types and helpers for the wait-state SRAM slave.
package ahb_sram_ws_pkg;

   typedef enum logic [1:0] {
      HtransIdle   = 2'b00,
      HtransBusy   = 2'b01,
      HtransNonseq = 2'b10,
      HtransSeq    = 2'b11
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      Size8, Size16, Size32, Size64, Size128, Size256, Size512, Size1024
   } hsize_t;

   typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_t;

   // Widest supported bus is 1024 bits, i.e. 128 byte lanes.
   localparam int unsigned MaxStrbW = 128;

   function automatic logic [MaxStrbW-1:0] lane_mask(input logic [2:0] hsize,
                                                      input logic [6:0] addr_lo);
      logic [MaxStrbW-1:0] ones;
      ones = (MaxStrbW'(1) << (8'd1 << hsize)) - MaxStrbW'(1);
      return ones << addr_lo;
   endfunction

endpackage

// File: rtl/ahb_sram_ws_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the SRAM slave.
interface ahb_sram_ws_if #(
   parameter int unsigned HADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned HBURST_WIDTH  = 3,
   parameter int unsigned HPROT_WIDTH   = 4,
   parameter int unsigned HMASTER_WIDTH = 4
);
   logic                       hsel;
   logic [HADDR_WIDTH-1:0]     haddr;
   logic [1:0]                 htrans;
   logic                       hwrite;
   logic [2:0]                 hsize;
   logic [HBURST_WIDTH-1:0]    hburst;
   logic [HPROT_WIDTH-1:0]     hprot;
   logic [HMASTER_WIDTH-1:0]   hmaster;
   logic                       hmasterlock;
   logic                       hnonsec;
   logic [DATA_WIDTH-1:0]      hwdata;
   logic [DATA_WIDTH/8-1:0]    hwstrb;
   logic                       hready;
   logic [DATA_WIDTH-1:0]      hrdata;
   logic                       hreadyout;
   logic                       hresp;
   logic                       hexokay;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmaster, hmasterlock,
             hnonsec, hwdata, hwstrb, hready,
      input  hrdata, hreadyout, hresp, hexokay
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmaster, hmasterlock,
             hnonsec, hwdata, hwstrb, hready,
      output hrdata, hreadyout, hresp, hexokay
   );
endinterface

// File: rtl/ahb_sram_ws_sram_sp_bw.sv
// Word array with byte write enables and a registered (synchronous) read port.
module ahb_sram_ws_sram_sp_bw #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MEM_DEPTH  = 256
) (
   input  logic                         hclk,
   input  logic                         hresetn,
   input  logic                         we,
   input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH/8-1:0]      wbe,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic                         re,
   input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]        rdata
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge hclk) begin
      if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Only the output register is reset; array contents survive reset.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave: programmable wait states, byte-lane masking, read-after-write
// forwarding and a two-cycle ERROR response for bad transfers.
module ahb_sram_ws
   import ahb_sram_ws_pkg::*;
#(
   parameter int unsigned HADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned MEM_DEPTH     = 256,
   parameter int unsigned WAIT_STATES   = 0,
   parameter int unsigned HBURST_WIDTH  = 3,
   parameter int unsigned HPROT_WIDTH   = 4,
   parameter int unsigned HMASTER_WIDTH = 4
) (
   input logic         hclk,
   input logic         hresetn,
   ahb_sram_ws_if.slave bus
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned BOFF   = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
   localparam int unsigned unused_side_w = HADDR_WIDTH + HBURST_WIDTH + HPROT_WIDTH +
                                           HMASTER_WIDTH;

   state_t                state_q;
   logic [2:0]            cnt_q;
   logic                  hreadyout_q;
   logic                  hresp_q;
   logic                  wr_pend_q;
   logic [IDX_W-1:0]      widx_q;
   logic [STRB_W-1:0]     wmask_q;
   logic [STRB_W-1:0]     fwd_be_q;
   logic [DATA_WIDTH-1:0] fwd_data_q;

   logic                  accept, err, out_of_range, oversize, unaligned;
   logic [6:0]            align_mask, addr_lo;
   logic [IDX_W-1:0]      idx;
   logic [MaxStrbW-1:0]   lm_full;
   logic [STRB_W-1:0]     size_mask;
   logic                  we, re;
   logic [STRB_W-1:0]     wbe, fwd_be;
   logic [DATA_WIDTH-1:0] sram_rdata, hrdata_mux;

   always_comb begin
      accept       = bus.hsel & bus.hready &
                     (htrans_t'(bus.htrans) inside {HtransNonseq, HtransSeq});
      out_of_range = (bus.haddr >> (BOFF + IDX_W)) != '0;
      oversize     = bus.hsize > 3'(BOFF);
      align_mask   = (7'd1 << bus.hsize) - 7'd1;
      unaligned    = (bus.haddr[6:0] & align_mask) != 7'd0;
      err          = out_of_range | oversize | unaligned;
      idx          = IDX_W'(bus.haddr >> BOFF);
      addr_lo      = bus.haddr[6:0] & 7'(STRB_W - 1);
      lm_full      = lane_mask(bus.hsize, addr_lo);
      size_mask    = lm_full[STRB_W-1:0];
      // Write commits on the last (ready) data-phase cycle; reset drops it.
      we           = hresetn & wr_pend_q & (state_q == StData) & (cnt_q == 3'd0);
      wbe          = wmask_q & bus.hwstrb;
      re           = accept & ~err & ~bus.hwrite;
      fwd_be       = (we && (widx_q == idx)) ? wbe : '0;
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
         wr_pend_q   <= 1'b0;
         widx_q      <= '0;
         wmask_q     <= '0;
         fwd_be_q    <= '0;
         fwd_data_q  <= '0;
      end else begin
         if (re) begin
            fwd_be_q   <= fwd_be;
            fwd_data_q <= bus.hwdata;
         end
         case (state_q)
            StErr1: begin
               state_q     <= StErr2;
               hreadyout_q <= 1'b1;
               hresp_q     <= HRESP_ERROR;
            end
            default: begin
               if (state_q == StData && cnt_q != 3'd0) begin
                  cnt_q       <= cnt_q - 3'd1;
                  hreadyout_q <= (cnt_q == 3'd1);
               end else if (accept && !err) begin
                  state_q     <= StData;
                  cnt_q       <= 3'(WAIT_STATES);
                  hreadyout_q <= (WAIT_STATES == 0);
                  hresp_q     <= HRESP_OKAY;
                  wr_pend_q   <= bus.hwrite;
                  widx_q      <= idx;
                  wmask_q     <= size_mask;
               end else if (accept) begin
                  state_q     <= StErr1;
                  hreadyout_q <= 1'b0;
                  hresp_q     <= HRESP_ERROR;
                  wr_pend_q   <= 1'b0;
               end else begin
                  state_q     <= StIdle;
                  hreadyout_q <= 1'b1;
                  hresp_q     <= HRESP_OKAY;
                  wr_pend_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   ahb_sram_ws_sram_sp_bw #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_sram (
      .hclk    (hclk),
      .hresetn (hresetn),
      .we      (we),
      .waddr   (widx_q),
      .wbe     (wbe),
      .wdata   (bus.hwdata),
      .re      (re),
      .raddr   (idx),
      .rdata   (sram_rdata)
   );

   // Lanes written at the read's accept edge come from the captured write data.
   always_comb begin
      hrdata_mux = sram_rdata;
      for (int b = 0; b < STRB_W; b++) begin
         if (fwd_be_q[b]) hrdata_mux[b*8 +: 8] = fwd_data_q[b*8 +: 8];
      end
   end

   assign bus.hrdata    = hrdata_mux;
   assign bus.hreadyout = hreadyout_q;
   assign bus.hresp     = hresp_q;
   assign bus.hexokay   = 1'b0;

   logic unused_sideband;
   assign unused_sideband = ^{bus.hburst, bus.hprot, bus.hmaster, bus.hmasterlock,
                              bus.hnonsec, bus.htrans[0], lm_full, 32'(unused_side_w)};

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Directed bench: one slave with zero wait states and one with two wait states.
module tb_ahb_sram_ws;

   logic hclk;
   logic hresetn;
   int   errors;
   int   checks;
   int   lows;

   ahb_sram_ws_if #(.HADDR_WIDTH(32), .DATA_WIDTH(64)) b0 ();
   ahb_sram_ws_if #(.HADDR_WIDTH(32), .DATA_WIDTH(64)) b2 ();

   ahb_sram_ws #(.WAIT_STATES(0)) dut0 (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (b0)
   );

   ahb_sram_ws #(.WAIT_STATES(2)) dut2 (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (b2)
   );

   assign b0.hready = b0.hreadyout;
   assign b2.hready = b2.hreadyout;

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic a0(input logic [31:0] addr, input logic wr, input logic [2:0] sz);
      b0.hsel = 1'b1; b0.htrans = 2'b10; b0.haddr = addr; b0.hwrite = wr; b0.hsize = sz;
   endtask

   task automatic a2(input logic [31:0] addr, input logic wr, input logic [2:0] sz);
      b2.hsel = 1'b1; b2.htrans = 2'b10; b2.haddr = addr; b2.hwrite = wr; b2.hsize = sz;
   endtask

   task automatic idle0();
      b0.hsel = 1'b0; b0.htrans = 2'b00;
   endtask

   task automatic idle2();
      b2.hsel = 1'b0; b2.htrans = 2'b00;
   endtask

   task automatic wr0(input logic [31:0] addr, input logic [2:0] sz, input logic [63:0] wd,
                      input logic [7:0] st, input string tag);
      a0(addr, 1'b1, sz);
      step();
      idle0();
      b0.hwdata = wd; b0.hwstrb = st;
      chk({tag, "_rdy"}, 64'(b0.hreadyout), 64'd1);
      chk({tag, "_resp"}, 64'(b0.hresp), 64'd0);
      step();
   endtask

   task automatic rd0(input logic [31:0] addr, input logic [2:0] sz, input logic [63:0] exp,
                      input string tag);
      a0(addr, 1'b0, sz);
      step();
      idle0();
      chk(tag, b0.hrdata, exp);
      chk({tag, "_rdy"}, 64'(b0.hreadyout), 64'd1);
      step();
   endtask

   task automatic err0(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                       input string tag);
      a0(addr, wr, sz);
      step();
      idle0();
      b0.hwdata = '1; b0.hwstrb = '1;
      chk({tag, "_e1_rdy"}, 64'(b0.hreadyout), 64'd0);
      chk({tag, "_e1_resp"}, 64'(b0.hresp), 64'd1);
      step();
      chk({tag, "_e2_rdy"}, 64'(b0.hreadyout), 64'd1);
      chk({tag, "_e2_resp"}, 64'(b0.hresp), 64'd1);
      step();
      chk({tag, "_after_resp"}, 64'(b0.hresp), 64'd0);
   endtask

   task automatic ws2(input logic [31:0] addr, input logic wr, input logic [63:0] wd,
                      input logic [63:0] exp, input string tag);
      a2(addr, wr, 3'd3);
      step();
      idle2();
      b2.hwdata = wd; b2.hwstrb = 8'hFF;
      lows = 0;
      while (b2.hreadyout !== 1'b1 && lows < 10) begin
         lows++;
         step();
      end
      chk({tag, "_low_cycles"}, 64'(lows), 64'd2);
      if (!wr) chk(tag, b2.hrdata, exp);
      chk({tag, "_resp"}, 64'(b2.hresp), 64'd0);
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      hresetn = 1'b0;
      b0.hsel = 1'b0; b0.haddr = '0; b0.htrans = 2'b00; b0.hwrite = 1'b0; b0.hsize = 3'd0;
      b0.hburst = '0; b0.hprot = '0; b0.hmaster = '0; b0.hmasterlock = 1'b0;
      b0.hnonsec = 1'b0; b0.hwdata = '0; b0.hwstrb = '0;
      b2.hsel = 1'b0; b2.haddr = '0; b2.htrans = 2'b00; b2.hwrite = 1'b0; b2.hsize = 3'd0;
      b2.hburst = '0; b2.hprot = '0; b2.hmaster = '0; b2.hmasterlock = 1'b0;
      b2.hnonsec = 1'b0; b2.hwdata = '0; b2.hwstrb = '0;
      step();
      step();
      hresetn = 1'b1;

      chk("rst_rdy", 64'(b0.hreadyout), 64'd1);
      chk("rst_resp", 64'(b0.hresp), 64'd0);
      chk("rst_hrdata", b0.hrdata, 64'd0);
      chk("hexokay0", 64'(b0.hexokay), 64'd0);
      chk("hexokay2", 64'(b2.hexokay), 64'd0);

      // Full word, byte, and strobed word writes
      wr0(32'h10, 3'd3, 64'h1122334455667788, 8'hFF, "w10");
      rd0(32'h10, 3'd3, 64'h1122334455667788, "r10_full");
      wr0(32'h13, 3'd0, 64'hFFFFFFFFAAFFFFFF, 8'hFF, "w13_byte");
      rd0(32'h10, 3'd3, 64'h11223344AA667788, "r10_byte");
      wr0(32'h14, 3'd2, 64'h9988776600000000, 8'h30, "w14_strb");
      rd0(32'h10, 3'd3, 64'h11227766AA667788, "r10_strb");
      wr0(32'h10, 3'd3, 64'h0, 8'h00, "w10_nolanes");
      rd0(32'h10, 3'd3, 64'h11227766AA667788, "r10_nolanes");

      // hsel low: no access
      b0.hsel = 1'b0; b0.htrans = 2'b10; b0.haddr = 32'h10; b0.hwrite = 1'b1;
      b0.hsize = 3'd3;
      step();
      idle0();
      b0.hwdata = 64'h0; b0.hwstrb = 8'hFF;
      chk("nosel_rdy", 64'(b0.hreadyout), 64'd1);
      step();
      rd0(32'h10, 3'd3, 64'h11227766AA667788, "r10_nosel");

      // Pipelined write then read of the same word
      wr0(32'h20, 3'd3, 64'h0, 8'hFF, "w20_clear");
      a0(32'h20, 1'b1, 3'd3);
      step();
      b0.hwdata = 64'hDEADBEEFCAFEF00D; b0.hwstrb = 8'hFF;
      a0(32'h20, 1'b0, 3'd3);
      step();
      idle0();
      chk("fwd_full", b0.hrdata, 64'hDEADBEEFCAFEF00D);
      step();
      a0(32'h22, 1'b1, 3'd1);
      step();
      b0.hwdata = 64'h0000000012340000; b0.hwstrb = 8'hFF;
      a0(32'h20, 1'b0, 3'd3);
      step();
      idle0();
      chk("fwd_partial", b0.hrdata, 64'hDEADBEEF1234F00D);
      step();
      rd0(32'h20, 3'd3, 64'hDEADBEEF1234F00D, "r20_array");

      // Back-to-back reads, one per cycle
      a0(32'h10, 1'b0, 3'd3);
      step();
      chk("b2b_first", b0.hrdata, 64'h11227766AA667788);
      chk("b2b_first_rdy", 64'(b0.hreadyout), 64'd1);
      a0(32'h20, 1'b0, 3'd3);
      step();
      idle0();
      chk("b2b_second", b0.hrdata, 64'hDEADBEEF1234F00D);
      step();

      // Error responses
      wr0(32'h00, 3'd3, 64'h0123456789ABCDEF, 8'hFF, "w00");
      err0(32'h800, 1'b0, 3'd3, "oor_read");
      chk("oor_hrdata_held", b0.hrdata, 64'hDEADBEEF1234F00D);
      err0(32'h02, 1'b1, 3'd2, "unaligned_wr");
      err0(32'h00, 1'b0, 3'd4, "oversize_rd");
      rd0(32'h00, 3'd3, 64'h0123456789ABCDEF, "r00_unchanged");
      wr0(32'h7F8, 3'd3, 64'hCAFE0000BEEF1111, 8'hFF, "w_last");
      rd0(32'h7F8, 3'd3, 64'hCAFE0000BEEF1111, "r_last");

      // Two wait states
      ws2(32'h10, 1'b1, 64'hA5A55A5A0F0FF0F0, 64'h0, "ws_wr");
      ws2(32'h10, 1'b0, 64'h0, 64'hA5A55A5A0F0FF0F0, "ws_rd");

      // Reset in the middle of reads on both slaves
      a0(32'h10, 1'b0, 3'd3);
      a2(32'h10, 1'b0, 3'd3);
      step();
      idle0();
      idle2();
      hresetn = 1'b0;
      step();
      step();
      hresetn = 1'b1;
      chk("midrst_rdy0", 64'(b0.hreadyout), 64'd1);
      chk("midrst_resp0", 64'(b0.hresp), 64'd0);
      chk("midrst_hrdata0", b0.hrdata, 64'd0);
      chk("midrst_rdy2", 64'(b2.hreadyout), 64'd1);
      chk("midrst_hrdata2", b2.hrdata, 64'd0);
      rd0(32'h10, 3'd3, 64'h11227766AA667788, "post_rst_r10");
      ws2(32'h10, 1'b0, 64'h0, 64'hA5A55A5A0F0FF0F0, "post_rst_ws");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
